// File: rtl/sobel_pkg.sv
// Purpose: shared constants and state encoding for the Sobel write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sobel_pkg;

  localparam int IMG_ROWS = 540;
  localparam int IMG_COLS = 540;
  // The 3x3 kernel loses one pixel on every border.
  localparam int OUT_ROWS = IMG_ROWS - 2;
  localparam int OUT_COLS = IMG_COLS - 2;
  localparam int ADDR_W   = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sobel_wb_fifo.sv
// Purpose: register-array FIFO with show-ahead head, generic width/depth.
// Latency: an entry pushed in cycle N is visible on head_dat in cycle N+1.
// Backpressure: push is accepted when not full, or when full with a pop in the same cycle.
// Ports: clk/rst (sync, active-high); push_vld/push_dat write side;
//        pop_rdy consumes the head; head_dat/full/empty/count status.
module sobel_wb_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_rdy & (cnt_q != '0);
    // When full, the slot being written is the one being popped this cycle;
    // the head is read combinationally before the edge, so this is safe.
    do_push = push_vld & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    // Power-of-two depth: pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

endmodule

// File: rtl/sobel_wb.sv
// Purpose: buffers the Sobel core pixel stream and writes it to frame memory with linear addresses.
// Latency: pixel accepted in cycle N is presented on MEM_WE_O/MEM_WDATA_O in cycle N+1.
// Backpressure: none toward the core; pixels arriving with the FIFO full are dropped and flagged on OVF_O.
// Ports: CLK/RST (sync, active-high); START_I arms a frame; PIXEL_I/PIXEL_EN_I core stream;
//        MEM_WE_O/MEM_ADDR_O/MEM_WDATA_O/MEM_READY_I memory write port;
//        BUSY_O (not IDLE), DONE_O (one-cycle frame end), OVF_O (sticky drop flag).
module sobel_wb #(
  parameter int                OUT_COLS   = sobel_pkg::OUT_COLS,
  parameter int                OUT_ROWS   = sobel_pkg::OUT_ROWS,
  parameter int                FIFO_DEPTH = 16,
  parameter int                ADDR_W     = sobel_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START_I,
  input  logic [7:0]        PIXEL_I,
  input  logic              PIXEL_EN_I,
  input  logic              MEM_READY_I,
  output logic              MEM_WE_O,
  output logic [ADDR_W-1:0] MEM_ADDR_O,
  output logic [7:0]        MEM_WDATA_O,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic              OVF_O
);

  import sobel_pkg::*;

  localparam int                TOTAL    = OUT_COLS * OUT_ROWS;
  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int                ENT_W    = ADDR_W + 8;
  // Terminate on the last counted pixel so in_cnt never needs to hold TOTAL
  // itself (TOTAL may equal 2^ADDR_W).
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pix_vld, push_vld, drop, wr_vld, wr_fire;
  logic [ENT_W-1:0]  head_dat;
  logic [ADDR_W-1:0] head_off;
  logic [7:0]        head_pix;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;

  // Each entry carries its pixel index, so a dropped pixel leaves a hole in
  // memory instead of shifting every later pixel down by one.
  sobel_wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push_vld (push_vld),
    .push_dat ({in_cnt_q, PIXEL_I}),
    .pop_rdy  (wr_fire),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign head_off = head_dat[ENT_W-1:8];
  assign head_pix = head_dat[7:0];

  always_comb begin
    wr_vld   = ((state_q == RUN) | (state_q == DRAIN)) & ~fifo_empty;
    wr_fire  = wr_vld & MEM_READY_I;
    pix_vld  = (state_q == RUN) & PIXEL_EN_I;
    push_vld = pix_vld & (~fifo_full | wr_fire);
    drop     = pix_vld & ~push_vld;
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (START_I) begin
          state_d  = RUN;
          in_cnt_d = '0;
          addr_d   = BASE_ADDR;
          ovf_d    = 1'b0;
        end
      end
      RUN: begin
        if (pix_vld) begin
          in_cnt_d = in_cnt_q + ADDR_W'(1);
          if (in_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
        if (drop) begin
          ovf_d = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_cnt == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Address follows the entry just written so the idle address points one
    // past the last written location.
    if (wr_fire) begin
      addr_d = BASE_ADDR + head_off + ADDR_W'(1);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      addr_q   <= BASE_ADDR;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign MEM_WE_O    = wr_vld;
  assign MEM_ADDR_O  = fifo_empty ? addr_q : (BASE_ADDR + head_off);
  assign MEM_WDATA_O = fifo_empty ? 8'd0 : head_pix;
  assign BUSY_O      = busy_q;
  assign DONE_O      = done_q;
  assign OVF_O       = ovf_q;

endmodule

// File: tb/tb_sobel_wb.sv
// Purpose: directed bench for sobel_wb on a 4x4 frame with a 4-deep FIFO.
// Latency: n/a.
// Backpressure: MEM_READY_I patterns are driven per scenario.
module tb_sobel_wb;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 19;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START_I = 1'b0;
  logic [7:0]    PIXEL_I = 8'd0;
  logic          PIXEL_EN_I = 1'b0;
  logic          MEM_READY_I = 1'b1;
  logic          MEM_WE_O;
  logic [AW-1:0] MEM_ADDR_O;
  logic [7:0]    MEM_WDATA_O;
  logic          BUSY_O;
  logic          DONE_O;
  logic          OVF_O;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cyc[$];
  int stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_data = '0;

  sobel_wb #(
    .OUT_COLS   (COLS),
    .OUT_ROWS   (ROWS),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .BASE_ADDR  ('0)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START_I     (START_I),
    .PIXEL_I     (PIXEL_I),
    .PIXEL_EN_I  (PIXEL_EN_I),
    .MEM_READY_I (MEM_READY_I),
    .MEM_WE_O    (MEM_WE_O),
    .MEM_ADDR_O  (MEM_ADDR_O),
    .MEM_WDATA_O (MEM_WDATA_O),
    .BUSY_O      (BUSY_O),
    .DONE_O      (DONE_O),
    .OVF_O       (OVF_O)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (prev_stall && (MEM_WE_O !== 1'b1 || MEM_ADDR_O !== prev_addr || MEM_WDATA_O !== prev_data))
        stall_err++;
      if (MEM_WE_O === 1'b1 && MEM_READY_I === 1'b1) begin
        wr_addr.push_back(int'(MEM_ADDR_O));
        wr_data.push_back(int'(MEM_WDATA_O));
        wr_cyc.push_back(cyc_cnt);
      end
      if (DONE_O === 1'b1) done_cyc.push_back(cyc_cnt);
    end
    prev_stall = !RST && MEM_WE_O === 1'b1 && MEM_READY_I === 1'b0;
    prev_addr  = MEM_ADDR_O;
    prev_data  = MEM_WDATA_O;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic st, input logic en, input logic [7:0] pix, input logic rdy);
    START_I     = st;
    PIXEL_EN_I  = en;
    PIXEL_I     = pix;
    MEM_READY_I = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    stall_err = 0;
  endtask

  task automatic wait_done(input logic rdy, input string name);
    int n = 0;
    while (DONE_O !== 1'b1 && n < 64) begin
      drive(1'b0, 1'b0, 8'd0, rdy);
      n++;
    end
    checks++;
    if (DONE_O !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: DONE_O=%0b after %0d cycles, expected 1", name, DONE_O, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (MEM_WE_O !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", MEM_WE_O); end
    checks++; if (MEM_ADDR_O !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", MEM_ADDR_O); end
    checks++; if (MEM_WDATA_O !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0d expected 0", MEM_WDATA_O); end
    checks++; if (BUSY_O !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", BUSY_O); end
    checks++; if (DONE_O !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", DONE_O); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", OVF_O); end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int first_cyc;
    clear_mon();
    drive(1'b1, 1'b0, 8'd0, 1'b1);
    checks++; if (BUSY_O !== 1'b1) begin errors++; $display("FAIL basic_busy_run: got %0b expected 1", BUSY_O); end
    first_cyc = cyc_cnt;
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b1);
    wait_done(1'b1, "basic");
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (BUSY_O !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b expected 0", BUSY_O); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b expected 0", OVF_O); end
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL basic_nwrites: got %0d expected 16", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] != i) begin
        errors++; $display("FAIL basic_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, i);
      end
    end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cyc.size()); end
    if (wr_cyc.size() > 0) begin
      checks++;
      if (wr_cyc[0] != first_cyc + 1) begin errors++; $display("FAIL basic_latency: first write cycle %0d expected %0d", wr_cyc[0], first_cyc + 1); end
      if (done_cyc.size() > 0) begin
        checks++;
        if (done_cyc[0] - wr_cyc[wr_cyc.size()-1] != 2) begin
          errors++; $display("FAIL basic_done_gap: got %0d cycles expected 2", done_cyc[0] - wr_cyc[wr_cyc.size()-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int pix = 0;
    logic rdy;
    clear_mon();
    drive(1'b1, 1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 100; k++) begin
      rdy = (k % 4 == 0) || (k % 4 == 3);
      if (k % 2 == 0 && pix < 16) begin
        drive(1'b0, 1'b1, 8'(8'h80 + pix), rdy);
        pix++;
      end else begin
        drive(1'b0, 1'b0, 8'd0, rdy);
      end
      if (DONE_O === 1'b1) break;
    end
    checks++; if (DONE_O !== 1'b1) begin errors++; $display("FAIL bp_done: got %0b expected 1", DONE_O); end
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable stalls expected 0", stall_err); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %0b expected 0", OVF_O); end
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL bp_nwrites: got %0d expected 16", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] != 8'h80 + i) begin
        errors++; $display("FAIL bp_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, 8'h80 + i);
      end
    end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cyc.size()); end
  endtask

  task automatic test_ignored();
    int n = 0;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h55, 1'b1);
      drive(1'b0, 1'b0, 8'd0, 1'b1);
    end
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL ign_idle_writes: got %0d expected 0", wr_addr.size()); end
    checks++; if (BUSY_O !== 1'b0) begin errors++; $display("FAIL ign_idle_busy: got %0b expected 0", BUSY_O); end
    drive(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 16; i++) drive((i == 8) ? 1'b1 : 1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
    // Frame now draining: stall memory so DRAIN lasts, keep pixels coming.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'hEE, 1'b0);
    while (DONE_O !== 1'b1 && n < 20) begin
      drive(1'b0, 1'b1, 8'hEE, 1'b1);
      n++;
    end
    checks++; if (DONE_O !== 1'b1) begin errors++; $display("FAIL ign_done: got %0b expected 1", DONE_O); end
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL ign_nwrites: got %0d expected 16", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] != 8'h60 + i) begin
        errors++; $display("FAIL ign_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, 8'h60 + i);
      end
    end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", done_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    checks++; if (OVF_O !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf: got %0b expected 1", OVF_O); end
    RST = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    RST = 1'b0;
    checks++; if (MEM_WE_O !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %0b expected 0", MEM_WE_O); end
    checks++; if (BUSY_O !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", BUSY_O); end
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %0b expected 0", OVF_O); end
    checks++; if (DONE_O !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %0b expected 0", DONE_O); end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (wr_addr.size() != 0 || done_cyc.size() != 0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d writes %0d dones expected 0 and 0", wr_addr.size(), done_cyc.size());
    end
    clear_mon();
    drive(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
    wait_done(1'b1, "rst_mid");
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL rst_mid_nwrites: got %0d expected 16", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] != 8'h10 + i) begin
        errors++; $display("FAIL rst_mid_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, 8'h10 + i);
      end
    end
  endtask

  // Leaves the bench in the DONE cycle of the overflow frame.
  task automatic test_overflow();
    int exp_a[$];
    clear_mon();
    exp_a = '{0, 1, 2, 3};
    for (int i = 6; i < 16; i++) exp_a.push_back(i);
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    checks++; if (OVF_O !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", OVF_O); end
    checks++; if (MEM_WE_O !== 1'b1 || MEM_ADDR_O !== '0 || MEM_WDATA_O !== 8'h40) begin
      errors++; $display("FAIL ovf_head: got we %0b addr %0d data %0d expected we 1 addr 0 data 64", MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O);
    end
    for (int i = 6; i < 16; i++) drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
    checks++; if (OVF_O !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", OVF_O); end
    wait_done(1'b1, "ovf");
    checks++; if (wr_addr.size() != exp_a.size()) begin errors++; $display("FAIL ovf_nwrites: got %0d expected %0d", wr_addr.size(), exp_a.size()); end
    for (int i = 0; i < wr_addr.size() && i < exp_a.size(); i++) begin
      checks++;
      if (wr_addr[i] != exp_a[i] || wr_data[i] != 8'h40 + exp_a[i]) begin
        errors++; $display("FAIL ovf_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], exp_a[i], 8'h40 + exp_a[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    clear_mon();
    drive(1'b1, 1'b0, 8'd0, 1'b1);
    checks++; if (OVF_O !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear: got %0b expected 0", OVF_O); end
    checks++; if (BUSY_O !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b expected 1", BUSY_O); end
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
    wait_done(1'b1, "b2b");
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL b2b_nwrites: got %0d expected 16", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] != i || wr_data[i] != 8'h20 + i) begin
        errors++; $display("FAIL b2b_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, 8'h20 + i);
      end
    end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cyc.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
